// File: rtl/fence_buffer_pkg.sv
// fence_buffer_pkg -- shared definitions for the raw-hits RAM write controller.
//   fence_state_e : write-controller FSM encodings (INIT=0, PRESTORE=1, RUN=2, HOLD=3)
//   setback_const : fixed part of the setback (read offset + 1 + prestore safety)
package fence_buffer_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_PRESTORE = 2'd1,
        ST_RUN      = 2'd2,
        ST_HOLD     = 2'd3
    } fence_state_e;

    // The pretrigger tbin part of the setback is runtime; this is the constant remainder.
    function automatic int setback_const(input int read_adr_offset, input int prestore_safety);
        return read_adr_offset + 32'sd1 + prestore_safety;
    endfunction

endpackage

// File: rtl/fence_buffer_ctrl_if.sv
// fence_buffer_ctrl_if -- fence allocation / RAM write bus of the raw-hits buffer.
//   master : user side (drives push/pop requests, reads RAM write strobes and head fence)
//   slave  : fence_buffer_ctrl side
//   push, push_adr, push_data : allocate a fence
//   pop, pop_adr              : release the head fence
//   fifo_wen, fifo_wadr       : raw-hits RAM write enable / address
//   wr_buf_ready              : buffer may accept a pretrigger
//   queue_adr, queue_data     : head fence address / data
interface fence_buffer_ctrl_if #(
    parameter int RAM_ADRB = 11,
    parameter int MXBDATA  = 32
);
    logic                push;
    logic [RAM_ADRB-1:0] push_adr;
    logic [MXBDATA-1:0]  push_data;
    logic                pop;
    logic [RAM_ADRB-1:0] pop_adr;
    logic                fifo_wen;
    logic [RAM_ADRB-1:0] fifo_wadr;
    logic                wr_buf_ready;
    logic [RAM_ADRB-1:0] queue_adr;
    logic [MXBDATA-1:0]  queue_data;

    modport master (
        output push, push_adr, push_data, pop, pop_adr,
        input  fifo_wen, fifo_wadr, wr_buf_ready, queue_adr, queue_data
    );

    modport slave (
        input  push, push_adr, push_data, pop, pop_adr,
        output fifo_wen, fifo_wadr, wr_buf_ready, queue_adr, queue_data
    );
endinterface

// File: rtl/fence_fifo.sv
// fence_fifo -- synchronous FIFO of 2**ADRB entries of WIDTH bits holding {data, adr}.
//   clock, reset (sync, active-high)
//   wr_en, wr_data : push ; rd_en : pop
//   rd_data        : head entry, registered (follows a head change by one clock)
//   full, empty    : status, registered one clock behind the occupancy so they line up with rd_data
//   ovf, udf       : sticky push-when-full / pop-when-empty
//   nwords         : current occupancy
module fence_fifo #(
    parameter int WIDTH = 43,
    parameter int ADRB  = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             udf,
    output logic [ADRB:0]    nwords
);
    localparam int            DEPTH    = 2**ADRB;
    localparam logic [ADRB:0] CNT_FULL = (ADRB+1)'(DEPTH);
    localparam logic [ADRB:0] CNT_ZERO = {(ADRB+1){1'b0}};
    localparam logic [ADRB:0] CNT_ONE  = (ADRB+1)'(1);
    localparam logic [ADRB-1:0] PTR_ONE = ADRB'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [ADRB-1:0]  wr_ptr_q, rd_ptr_q;
    logic [ADRB:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             full_q, empty_q, ovf_q, udf_q;
    logic             wr_ok_s, rd_ok_s;

    // Accept/reject decisions and next occupancy; a pop frees room for a same-clock push.
    always_comb begin
        wr_ok_s = wr_en && ((cnt_q != CNT_FULL) || rd_en);
        rd_ok_s = rd_en && (cnt_q != CNT_ZERO);
        case ({wr_ok_s, rd_ok_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage array write port.
    always_ff @(posedge clock) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers, occupancy, registered head and status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q  <= {ADRB{1'b0}};
            rd_ptr_q  <= {ADRB{1'b0}};
            cnt_q     <= CNT_ZERO;
            rd_data_q <= {WIDTH{1'b0}};
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            if (wr_ok_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_ok_s) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            cnt_q     <= cnt_d;
            rd_data_q <= mem_q[rd_ptr_q];
            full_q    <= (cnt_q == CNT_FULL);
            empty_q   <= (cnt_q == CNT_ZERO);
            ovf_q     <= ovf_q | (wr_en && !wr_ok_s);
            udf_q     <= udf_q | (rd_en && !rd_ok_s);
        end
    end

    assign rd_data = rd_data_q;
    assign full    = full_q;
    assign empty   = empty_q;
    assign ovf     = ovf_q;
    assign udf     = udf_q;
    assign nwords  = cnt_q;
endmodule

// File: rtl/fence_buffer_ctrl.sv
// fence_buffer_ctrl -- raw-hits RAM write controller with a fence queue.
// Generates the circular RAM write address/enable and stalls writing when the
// write pointer reaches the oldest allocated event (the head fence minus setback).
// Ports:
//   clock, reset (sync, active-high; frees all buffer space)
//   bus            : fence_buffer_ctrl_if.slave (push/pop, RAM write, ready, head fence)
//   pretrig_tbins  : per-source pretrigger tbins, source 0 in LSBs
//   no_raw_hits    : skip prestore
//   fence_dist_min : free distance required for wr_buf_ready
//   q_full, q_empty, ovf_err, udf_err, adr_err, stalled, stalled_once
//   fence_dist, fence_cnt, fence_cnt_peak, display
// Optional build macro FENCE_STALL_CNT_EN adds stall_cnt[15:0] (saturating HOLD clock count).
module fence_buffer_ctrl
    import fence_buffer_pkg::*;
#(
    parameter int RAM_ADRB        = 11,
    parameter int MXBDATA         = 32,
    parameter int NSRC            = 2,
    parameter int MXTBIN          = 5,
    parameter int READ_ADR_OFFSET = 6,
    parameter int PRESTORE_SAFETY = 2,
    parameter int PUP_DLY         = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    fence_buffer_ctrl_if.slave     bus,
    input  logic [NSRC*MXTBIN-1:0] pretrig_tbins,
    input  logic                   no_raw_hits,
    input  logic [RAM_ADRB-1:0]    fence_dist_min,
    output logic                   q_full,
    output logic                   q_empty,
    output logic                   ovf_err,
    output logic                   udf_err,
    output logic                   adr_err,
    output logic                   stalled,
    output logic                   stalled_once,
    output logic [RAM_ADRB-1:0]    fence_dist,
    output logic [RAM_ADRB:0]      fence_cnt,
    output logic [RAM_ADRB:0]      fence_cnt_peak,
    output logic [7:0]             display
`ifdef FENCE_STALL_CNT_EN
    ,
    output logic [15:0]            stall_cnt
`endif
);
    localparam int                RAM_DEPTH = 2**RAM_ADRB;
    localparam logic [RAM_ADRB-1:0] ADR_ZERO  = {RAM_ADRB{1'b0}};
    localparam logic [RAM_ADRB-1:0] ADR_ONE   = RAM_ADRB'(1);
    localparam logic [RAM_ADRB-1:0] DIST_MAX  = {RAM_ADRB{1'b1}};
    localparam logic [RAM_ADRB-1:0] SETBACK_K = RAM_ADRB'(setback_const(READ_ADR_OFFSET, PRESTORE_SAFETY));
    localparam int                PUP_W     = $clog2(PUP_DLY + 1) + 1;
    localparam logic [PUP_W-1:0]  PUP_END   = PUP_W'(PUP_DLY);
    localparam logic [PUP_W-1:0]  PUP_ONE   = PUP_W'(1);

    // Power-up hold counter: starts from configuration, deliberately not touched by reset.
    logic [PUP_W-1:0] pup_cnt_q = {PUP_W{1'b0}};
    logic             powered_s;

    fence_state_e        state_q, state_d;
    logic [RAM_ADRB-1:0] wadr_q, wadr_d, fence_dist_q, fence_dist_d;
    logic [RAM_ADRB-1:0] prestore_cnt_q, prestore_cnt_d;
    logic [RAM_ADRB-1:0] setback_s, next_fence_s, used_s, queue_adr_s;
    logic [MXTBIN-1:0]   tbin_max_s;
    logic                wen_q, wen_d, ready_q, ready_d, hit_fence_s;
    logic                stalled_q, stalled_once_q, adr_err_q, pop_q;
    logic [RAM_ADRB-1:0] pop_adr_q;
    logic [RAM_ADRB:0]   peak_q, fence_cnt_s;
    logic [7:0]          display_q, display_d;
    logic                q_empty_s;
    logic [MXBDATA+RAM_ADRB-1:0] head_s;

    fence_fifo #(.WIDTH(MXBDATA + RAM_ADRB), .ADRB(RAM_ADRB)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (bus.push),
        .wr_data ({bus.push_data, bus.push_adr}),
        .rd_en   (bus.pop),
        .rd_data (head_s),
        .full    (q_full),
        .empty   (q_empty_s),
        .ovf     (ovf_err),
        .udf     (udf_err),
        .nwords  (fence_cnt_s)
    );

    assign queue_adr_s = head_s[RAM_ADRB-1:0];
    assign powered_s   = (pup_cnt_q == PUP_END);

    // Power-up counter advance.
    always_ff @(posedge clock) begin
        if (!powered_s) pup_cnt_q <= pup_cnt_q + PUP_ONE;
        else            pup_cnt_q <= pup_cnt_q;
    end

    // Setback from the latest pretrigger source, and the address the writer must not reach.
    always_comb begin
        tbin_max_s = {MXTBIN{1'b0}};
        for (int s = 0; s < NSRC; s++) begin
            tbin_max_s = (pretrig_tbins[s*MXTBIN +: MXTBIN] > tbin_max_s) ?
                         pretrig_tbins[s*MXTBIN +: MXTBIN] : tbin_max_s;
        end
        setback_s    = RAM_ADRB'(tbin_max_s) + SETBACK_K;
        next_fence_s = queue_adr_s - setback_s;
    end

    // FSM next state.
    always_comb begin
        hit_fence_s = (fence_dist_q == ADR_ZERO);
        case (state_q)
            ST_INIT:     state_d = !powered_s ? ST_INIT : (no_raw_hits ? ST_RUN : ST_PRESTORE);
            // >= rather than == so a setback shrinking mid-prestore cannot trap the FSM here
            ST_PRESTORE: state_d = hit_fence_s ? ST_HOLD :
                                   ((prestore_cnt_q >= setback_s) ? ST_RUN : ST_PRESTORE);
            ST_RUN:      state_d = hit_fence_s ? ST_HOLD : ST_RUN;
            ST_HOLD:     state_d = (fence_dist_q > fence_dist_min) ?
                                   (no_raw_hits ? ST_RUN : ST_PRESTORE) : ST_HOLD;
            default:     state_d = ST_INIT;
        endcase
    end

    // Next values of the registered outputs. wen/ready are evaluated on next state and next
    // distance so their registers equal the decode of the current state and fence_dist.
    always_comb begin
        wadr_d         = wen_q ? (wadr_q + ADR_ONE) : wadr_q;
        // distance is taken against the next write address so it matches fifo_wadr when registered
        fence_dist_d   = q_empty_s ? DIST_MAX : (next_fence_s - wadr_d);
        wen_d          = (fence_dist_d != ADR_ZERO) &&
                         ((state_d == ST_PRESTORE) || (state_d == ST_RUN));
        ready_d        = (fence_dist_d != ADR_ZERO) && (state_d == ST_RUN) &&
                         (fence_dist_d > fence_dist_min);
        // counts the clock being entered, so PRESTORE lasts exactly setback clocks
        prestore_cnt_d = (state_d == ST_PRESTORE) ? (prestore_cnt_q + ADR_ONE) : ADR_ZERO;
        used_s         = DIST_MAX - fence_dist_d;
        display_d      = 8'h00;
        for (int k = 1; k < 8; k++) begin
            display_d[k] = ({1'b0, used_s} > (RAM_ADRB+1)'(RAM_DEPTH * k / 8));
        end
        display_d[0]   = !q_empty_s;
    end

    // Controller state and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_INIT;
            wadr_q         <= ADR_ZERO;
            wen_q          <= 1'b0;
            ready_q        <= 1'b0;
            fence_dist_q   <= DIST_MAX;
            prestore_cnt_q <= ADR_ZERO;
            stalled_q      <= 1'b0;
            stalled_once_q <= 1'b0;
            pop_q          <= 1'b0;
            pop_adr_q      <= ADR_ZERO;
            adr_err_q      <= 1'b0;
            peak_q         <= {(RAM_ADRB+1){1'b0}};
            display_q      <= 8'h00;
        end else begin
            state_q        <= state_d;
            wadr_q         <= wadr_d;
            wen_q          <= wen_d;
            ready_q        <= ready_d;
            fence_dist_q   <= fence_dist_d;
            prestore_cnt_q <= prestore_cnt_d;
            stalled_q      <= (state_d == ST_HOLD);
            stalled_once_q <= stalled_once_q | (state_d == ST_HOLD);
            pop_q          <= bus.pop;
            pop_adr_q      <= bus.pop_adr;
            // head is still the popped entry one clock after the pop
            adr_err_q      <= adr_err_q | (pop_q && (pop_adr_q != queue_adr_s));
            peak_q         <= (fence_cnt_s > peak_q) ? fence_cnt_s : peak_q;
            display_q      <= display_d;
        end
    end

`ifdef FENCE_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of clocks spent in HOLD.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= 16'h0000;
        end else if ((state_q == ST_HOLD) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign bus.fifo_wen     = wen_q;
    assign bus.fifo_wadr    = wadr_q;
    assign bus.wr_buf_ready = ready_q;
    assign bus.queue_adr    = queue_adr_s;
    assign bus.queue_data   = head_s[MXBDATA+RAM_ADRB-1:RAM_ADRB];
    assign q_empty          = q_empty_s;
    assign adr_err          = adr_err_q;
    assign stalled          = stalled_q;
    assign stalled_once     = stalled_once_q;
    assign fence_dist       = fence_dist_q;
    assign fence_cnt        = fence_cnt_s;
    assign fence_cnt_peak   = peak_q;
    assign display          = display_q;
endmodule
